// File: rtl/pc_pkg.sv
// Shared constants and types for the PC / return-address-stack unit.
package pc_pkg;

    // Default datapath geometry for the MIPS PC unit
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_PC_STEP  = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int DEF_RAS_DEPTH = 8;

    // Low bits of a jump target that come from the instruction (26-bit field << 2)
    localparam int JMP_FIELD_W = 28;

    // Which source fed the next PC, kept as a named signal for debug visibility
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_JMP = 2'd2,
        NPC_JR  = 2'd3
    } npc_src_e;

    // Fixed priority: jr, then j/jal, then taken branch, then sequential
    function automatic npc_src_e pick_npc_src(input logic jr_f, input logic jmp_f,
                                              input logic br_taken_f);
        npc_src_e src;
        if (jr_f)            src = NPC_JR;
        else if (jmp_f)      src = NPC_JMP;
        else if (br_taken_f) src = NPC_BR;
        else                 src = NPC_SEQ;
        return src;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push/pop/top with count and sticky
// overflow/underflow flags. When full, a push overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W,
    parameter int DEPTH = DEF_RAS_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    // ptr_q points at the next free slot; the top of stack is the slot below it.
    // Because DEPTH is a power of two the pointer wraps on its own, and when the
    // stack is full the next free slot is exactly the oldest entry.
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic full;
    logic empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state for pointer, count and sticky flags; pop has precedence over push
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (pop_i) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = ptr_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end else if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Control state registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk) begin
        if (push_i && !pop_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    assign top_o       = mem_q[ptr_q - PTR_W'(1)];
    assign count_o     = count_q;
    assign empty_o     = empty;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule

// File: rtl/pc_ras_unit.sv
// MIPS program-counter unit: PC register, prioritised next-PC selection
// (jr / j,jal / taken branch / sequential), stall, and a return-address
// stack that records jal links and checks jr targets against them.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int          PC_STEP   = DEF_PC_STEP,
    parameter int          RAS_DEPTH = DEF_RAS_DEPTH,
    localparam int         CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic              jal,
    input  logic              jr,
    input  logic [15:0]       imm,
    input  logic [25:0]       jump_addr,
    input  logic [ADDR_W-1:0] rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] npc,
    output logic [CNT_W-1:0]  ras_count,
    output logic              ras_mispredict,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int SHIFT = $clog2(PC_STEP);
    // Wide enough to hold the 28-bit jump field even when ADDR_W is smaller
    localparam int JW    = (ADDR_W > JMP_FIELD_W) ? ADDR_W : JMP_FIELD_W;

    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    br_target;
    logic [ADDR_W-1:0]    jmp_target;
    logic [ADDR_W+15:0]   imm_sx;
    logic [ADDR_W+15:0]   imm_off;
    logic [JW-1:0]        pc_plus_w;
    logic [JW-1:0]        jmp_w;
    npc_src_e             npc_src;

    logic                 ras_push;
    logic                 ras_pop;
    logic [ADDR_W-1:0]    ras_top;
    logic                 ras_empty;

    assign pc_plus = pc_q + ADDR_W'(PC_STEP);

    // Branch offset: sign-extend the 16-bit immediate, scale by the step size
    assign imm_sx    = {{ADDR_W{imm[15]}}, imm};
    assign imm_off   = imm_sx << SHIFT;
    assign br_target = pc_plus + imm_off[ADDR_W-1:0];

    // Jump target keeps the upper pc_plus bits above the 28-bit field
    assign pc_plus_w  = JW'(pc_plus);
    assign jmp_w      = (pc_plus_w & ~JW'({JMP_FIELD_W{1'b1}})) | JW'({jump_addr, 2'b00});
    assign jmp_target = jmp_w[ADDR_W-1:0];

    // Next-PC source and value; outputs follow inputs even while stalled
    always_comb begin
        npc_src = pick_npc_src(jr, jump | jal, branch & zero);
        npc     = pc_plus;
        case (npc_src)
            NPC_JR:  npc = rs_data;
            NPC_JMP: npc = jmp_target;
            NPC_BR:  npc = br_target;
            default: npc = pc_plus;
        endcase
    end

    // PC advances to the selected next PC unless stalled
    always_comb begin
        pc_d = stall ? pc_q : npc;
    end

    // PC register with asynchronous reset to RESET_PC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    // jr wins over jal: a combined jr+jal only pops
    assign ras_pop  = jr & ~stall;
    assign ras_push = jal & ~jr & ~stall;

    ras_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .empty_o     (ras_empty),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    // The RAS only predicts; the PC always follows rs_data on jr
    assign ras_mispredict = ras_empty | (rs_data != ras_top);

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed testbench for pc_ras_unit with hand-computed expectations.
module tb_pc_ras_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jal;
    logic        jr;
    logic [15:0] imm;
    logic [25:0] jump_addr;
    logic [31:0] rs_data;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] npc;
    logic [3:0]  ras_count;
    logic        ras_mispredict;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks;
    int errors;

    pc_ras_unit #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0),
        .PC_STEP   (4),
        .RAS_DEPTH (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch         (branch),
        .zero           (zero),
        .jump           (jump),
        .jal            (jal),
        .jr             (jr),
        .imm            (imm),
        .jump_addr      (jump_addr),
        .rs_data        (rs_data),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .npc            (npc),
        .ras_count      (ras_count),
        .ras_mispredict (ras_mispredict),
        .ras_overflow   (ras_overflow),
        .ras_underflow  (ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        stall = 0; branch = 0; zero = 0; jump = 0; jal = 0; jr = 0;
        imm = 16'h0; jump_addr = 26'h0; rs_data = 32'h0;
    endtask

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++;
        if (ras_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", ras_count); end
        checks++;
        if ({ras_overflow, ras_underflow} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: got %b want 00", {ras_overflow, ras_underflow});
        end
        reset = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL seq_start: got %h want %h", pc, exp_pc); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 32'(i * 4);
            checks++;
            if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, exp_pc); end
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1;
        #1;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0); end
        tick();
        reset = 0;
        tick();
        checks++;
        if (pc !== 32'h4) begin errors++; $display("FAIL after_reset_pc: got %h want %h", pc, 32'h4); end
    endtask

    task automatic test_branch();
        idle_inputs();
        jump = 1; jump_addr = 26'h10;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h40) begin errors++; $display("FAIL br_setup_pc: got %h want %h", pc, 32'h40); end
        branch = 1; zero = 1; imm = 16'hFFFE;
        #1;
        checks++;
        if (npc !== 32'h3C) begin errors++; $display("FAIL br_taken_npc: got %h want %h", npc, 32'h3C); end
        zero = 0;
        #1;
        checks++;
        if (npc !== 32'h44) begin errors++; $display("FAIL br_not_taken_npc: got %h want %h", npc, 32'h44); end
        zero = 1; imm = 16'h0010;
        #1;
        checks++;
        if (npc !== 32'h84) begin errors++; $display("FAIL br_fwd_npc: got %h want %h", npc, 32'h84); end
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h84) begin errors++; $display("FAIL br_taken_pc: got %h want %h", pc, 32'h84); end
    endtask

    task automatic test_jal_jr();
        idle_inputs();
        jump = 1; jump_addr = 26'h400;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h1000) begin errors++; $display("FAIL jal_setup_pc: got %h want %h", pc, 32'h1000); end
        jal = 1; jump_addr = 26'h100;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h400) begin errors++; $display("FAIL jal_pc: got %h want %h", pc, 32'h400); end
        checks++;
        if (ras_count !== 4'd1) begin errors++; $display("FAIL jal_count: got %0d want 1", ras_count); end
        jr = 1; rs_data = 32'h1004;
        #1;
        checks++;
        if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL jr_predict: got %b want 0", ras_mispredict); end
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h1004) begin errors++; $display("FAIL jr_pc: got %h want %h", pc, 32'h1004); end
        checks++;
        if (ras_count !== 4'd0) begin errors++; $display("FAIL jr_count: got %0d want 0", ras_count); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc;
        logic [31:0] links [1:9];
        exp_pc = 32'h1004;
        for (int i = 1; i <= 9; i++) begin
            idle_inputs();
            jal = 1; jump_addr = 26'(i * 32'h40);
            links[i] = exp_pc + 32'h4;
            exp_pc = 32'(i * 32'h100);
            tick();
            if (i == 8) begin
                checks++;
                if (ras_count !== 4'd8 || ras_overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_at_full: count %0d ovf %b want 8 0", ras_count, ras_overflow);
                end
            end
        end
        idle_inputs();
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL ovf_pc: got %h want %h", pc, exp_pc); end
        checks++;
        if (ras_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", ras_count); end
        checks++;
        if (ras_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", ras_overflow); end
        for (int i = 9; i >= 2; i--) begin
            jr = 1; rs_data = links[i];
            #1;
            checks++;
            if (ras_mispredict !== 1'b0) begin
                errors++; $display("FAIL lifo_pop%0d: mispredict %b want 0 (target %h)", i, ras_mispredict, links[i]);
            end
            tick();
            checks++;
            if (pc !== links[i] || ras_count !== 4'(i - 2)) begin
                errors++; $display("FAIL lifo_state%0d: pc %h count %0d want %h %0d", i, pc, ras_count, links[i], i - 2);
            end
        end
        idle_inputs();
        checks++;
        if (ras_underflow !== 1'b0 || ras_overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: ovf %b unf %b want 1 0", ras_overflow, ras_underflow);
        end
    endtask

    task automatic test_underflow();
        idle_inputs();
        jr = 1; rs_data = 32'h20;
        #1;
        checks++;
        if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL unf_mispredict: got %b want 1", ras_mispredict); end
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h20) begin errors++; $display("FAIL unf_pc: got %h want %h", pc, 32'h20); end
        checks++;
        if (ras_underflow !== 1'b1 || ras_count !== 4'd0) begin
            errors++; $display("FAIL unf_state: unf %b count %0d want 1 0", ras_underflow, ras_count);
        end
    endtask

    task automatic test_stall_priority();
        idle_inputs();
        stall = 1; jal = 1; jump_addr = 26'h50;
        #1;
        checks++;
        if (npc !== 32'h140 || pc_plus !== 32'h24) begin
            errors++; $display("FAIL stall_comb: npc %h pc_plus %h want 140 24", npc, pc_plus);
        end
        tick();
        checks++;
        if (pc !== 32'h20 || ras_count !== 4'd0) begin
            errors++; $display("FAIL stall_hold: pc %h count %0d want 20 0", pc, ras_count);
        end
        idle_inputs();
        jr = 1; jump = 1; branch = 1; zero = 1; imm = 16'h4; jump_addr = 26'h50; rs_data = 32'h88;
        #1;
        checks++;
        if (npc !== 32'h88) begin errors++; $display("FAIL prio_npc: got %h want %h", npc, 32'h88); end
        tick();
        idle_inputs();
        // one push, then jr+jal together must only pop
        jal = 1; jump_addr = 26'h80;
        tick();
        checks++;
        if (pc !== 32'h200 || ras_count !== 4'd1) begin
            errors++; $display("FAIL prio_push: pc %h count %0d want 200 1", pc, ras_count);
        end
        idle_inputs();
        jr = 1; jal = 1; rs_data = 32'h8C; jump_addr = 26'h80;
        tick();
        idle_inputs();
        checks++;
        if (pc !== 32'h8C || ras_count !== 4'd0) begin
            errors++; $display("FAIL jr_jal_pop_only: pc %h count %0d want 8c 0", pc, ras_count);
        end
    endtask

    task automatic test_wrap_and_reset_in_stall();
        idle_inputs();
        jr = 1; rs_data = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        checks++;
        if (pc_plus !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus: got %h want %h", pc_plus, 32'h0); end
        stall = 1; jal = 1;
        #2;
        reset = 1;
        #1;
        checks++;
        if (pc !== 32'h0 || ras_count !== 4'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++; $display("FAIL reset_in_stall: pc %h count %0d ovf %b unf %b want 0 0 0 0",
                               pc, ras_count, ras_overflow, ras_underflow);
        end
        tick();
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_sequential();
        test_async_reset();
        test_branch();
        test_jal_jr();
        test_overflow();
        test_underflow();
        test_stall_priority();
        test_wrap_and_reset_in_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
# pc_ras_unit

Parametrised program-counter unit for the single-cycle/multi-cycle MIPS datapath, successor to the original branch/jump PC block. Holds the PC register, computes the next PC from sequential, conditional-branch, jump, jump-and-link and jump-register sources with a fixed priority, and adds stall support. It also contains a circular return-address stack (RAS) that records `jal` link addresses and checks `jr` targets against them. It sits between the control unit/ALU and the instruction memory address port.

## Interface
- ADDR_W, 32, PC/address width (≥ 8)
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, sequential increment in bytes; branch offset shift is log2(PC_STEP)
- RAS_DEPTH, 8, RAS entries (power of two, ≥ 2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold PC and RAS this cycle
- branch  in  1  conditional branch decoded
- zero  in  1  ALU zero flag
- jump  in  1  `j` decoded
- jal  in  1  `jal` decoded (jump + link)
- jr  in  1  `jr` decoded
- imm  in  16  branch offset, signed
- jump_addr  in  26  jump target field
- rs_data  in  ADDR_W  register value for `jr`
- pc  out  ADDR_W  current PC (registered)
- pc_plus  out  ADDR_W  pc + PC_STEP (combinational)
- npc  out  ADDR_W  selected next PC (combinational)
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries
- ras_mispredict  out  1  `jr` target ≠ RAS top, or RAS empty (combinational, valid when jr=1)
- ras_overflow  out  1  sticky: push while full
- ras_underflow  out  1  sticky: pop while empty

## Operation
- Branch target: pc_plus + (sign-extended imm << log2(PC_STEP)), modulo 2^ADDR_W.
- Jump target: {pc_plus[ADDR_W-1:28], jump_addr, 2'b00}; for ADDR_W < 32, truncated to low ADDR_W bits.
- npc priority: jr → rs_data; else jump|jal → jump target; else branch&zero → branch target; else pc_plus.
- jal: pushes pc_plus into the RAS at the same edge at which the PC updates.
- jr: pops the RAS. ras_mispredict = (ras_count==0) | (rs_data ≠ top).
  - The RAS does not redirect the PC; rs_data is always the target.
- jr with jal also asserted: jr wins. Pop only, no push.
- Push when full:
  - overwrite the oldest entry (circular pointer);
  - ras_count stays RAS_DEPTH;
  - ras_overflow set.
- Pop when empty:
  - pointer and count unchanged;
  - ras_underflow set.
- stall=1:
  - PC, RAS, count and sticky flags hold;
  - npc/pc_plus still reflect the inputs.
- Sticky flags clear only on reset.

## Timing
- pc updates to npc on the rising clk edge when stall=0. Latency from decode inputs to pc is 1 cycle.
- Reset (asynchronous, any time, including mid-stall or mid-push):
  - pc = RESET_PC;
  - RAS pointer = 0, ras_count = 0;
  - ras_overflow = 0, ras_underflow = 0;
  - entry contents don't-care.
- Release of reset is synchronous to clk. The first PC update happens at the first rising edge with reset=0 and stall=0.
- RAS top and ras_count are updated at the same edge as pc. A push followed by a jr on the next cycle sees the new top.
- pc_plus wraps modulo 2^ADDR_W: pc = 2^ADDR_W − PC_STEP gives pc_plus = 0.

## Structure
- Shared package `pc_pkg`:
  - default ADDR_W/PC_STEP/RESET_PC constants;
  - npc-source enum (SEQ, BR, JMP, JR) for debug visibility.
- One sub-module, `ras_stack`, parametrised on width and depth:
  - push/pop/top interface;
  - count, overflow and underflow flags;
  - circular storage.
- Next-PC selection and the PC register stay in `pc_ras_unit`.

## Test plan
- Reset, then 3 cycles with no control inputs → pc = 0, 4, 8, 12. Assert reset mid-run → pc = 0 immediately, before any clock edge.
- Branch taken:
  - pc = 0x40, branch=1, zero=1, imm = 0xFFFE → npc = 0x3C.
  - Same with zero=0 → npc = 0x44.
- Jump and link then return:
  - pc = 0x1000, jal=1, jump_addr = 0x100 → pc = 0x400, ras_count = 1.
  - Next cycle, jr=1, rs_data = 0x1004 → pc = 0x1004, ras_mispredict = 0, ras_count = 0.
- Overflow: 9 consecutive jal with RAS_DEPTH = 8 → ras_count = 8, ras_overflow = 1. Eight jr pops return the last 8 links in LIFO order.
- Underflow/mispredict: jr with empty RAS, rs_data = 0x20 → pc = 0x20, ras_mispredict = 1, ras_underflow = 1, count = 0.
- Stall and priority:
  - stall=1 with jal=1 → pc and ras_count unchanged.
  - jr=1, jump=1, branch&zero=1 together → npc = rs_data.
